// File: rtl/rx_char_controller.sv
// Receive-side controller: sequences the character recovery receiver through
// reset/flush/run, buffers recovered characters in a FWFT FIFO and flags idle lines.
module rx_char_controller #(
    parameter int DATA_BITS    = 7,
    parameter int OVERSAMPLING = 17,
    parameter int FIFO_DEPTH   = 4,
    parameter int IDLE_CHARS   = 2
) (
    input  logic                               clk_i,
    input  logic                               rst_n_i,
    input  logic                               enable_i,
    input  logic                               clear_i,
    output logic                               rec_rst_o,
    input  logic [7:0]                         rec_char_i,
    input  logic                               rec_valid_i,
    output logic [DATA_BITS-1:0]               data_o,
    output logic                               data_valid_o,
    input  logic                               data_ready_i,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    count_o,
    output logic                               overrun_o,
    output logic                               idle_o,
    output logic [1:0]                         state_o
);

    localparam int AW             = $clog2(FIFO_DEPTH);
    localparam int CW             = $clog2(FIFO_DEPTH + 1);
    localparam int TIMEOUT_CYCLES = OVERSAMPLING * (DATA_BITS + 2) * IDLE_CHARS;
    localparam int TW             = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);
    localparam logic [TW-1:0] IDLE_LAST  = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] ST_DISABLED = 2'd0;
    localparam logic [1:0] ST_FLUSH    = 2'd1;
    localparam logic [1:0] ST_RUN      = 2'd2;

    logic [1:0]           state;
    logic [1:0]           state_next;
    logic                 flush_cnt;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        rd_ptr;
    logic [AW-1:0]        wr_ptr;
    logic [CW-1:0]        count;

    logic                 push_req;
    logic                 pop;
    logic                 full;
    logic                 push;
    logic                 drop;

    logic                 idle_armed;
    logic [TW-1:0]        idle_cnt;

    logic                 unused_rec_bits;

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            ST_DISABLED: begin
                if (enable_i) state_next = ST_FLUSH;
            end
            ST_FLUSH: begin
                if (!enable_i)     state_next = ST_DISABLED;
                else if (flush_cnt) state_next = ST_RUN;
            end
            ST_RUN: begin
                if (!enable_i) state_next = ST_DISABLED;
            end
            default: state_next = ST_DISABLED;
        endcase
    end

    // flush_cnt counts the two receiver-reset cycles spent in FLUSH
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state     <= ST_DISABLED;
            flush_cnt <= 1'b0;
        end else begin
            state     <= state_next;
            flush_cnt <= (state == ST_FLUSH) && (state_next == ST_FLUSH);
        end
    end

    assign rec_rst_o = (state != ST_RUN);
    assign state_o   = state;

    // ------------------------------------------------------------------
    // First-word fall-through FIFO
    // ------------------------------------------------------------------
    assign push_req = (state == ST_RUN) && rec_valid_i;
    assign pop      = (count != '0) && data_ready_i;
    assign full     = (count == FULL_COUNT);
    assign push     = push_req && (!full || pop);
    assign drop     = push_req && full && !pop;

    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr] <= rec_char_i[DATA_BITS-1:0];
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign data_o       = mem[rd_ptr];
    assign data_valid_o = (count != '0);
    assign count_o      = count;

    // A fresh drop takes priority over a simultaneous clear
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)     overrun_o <= 1'b0;
        else if (drop)    overrun_o <= 1'b1;
        else if (clear_i) overrun_o <= 1'b0;
    end

    // ------------------------------------------------------------------
    // Idle-line timer: armed by any strobe in RUN, including dropped ones
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            idle_armed <= 1'b0;
            idle_cnt   <= '0;
            idle_o     <= 1'b0;
        end else begin
            idle_o <= 1'b0;
            if (state != ST_RUN) begin
                idle_armed <= 1'b0;
                idle_cnt   <= '0;
            end else if (rec_valid_i) begin
                idle_armed <= 1'b1;
                idle_cnt   <= '0;
            end else if (idle_armed) begin
                if (idle_cnt == IDLE_LAST) begin
                    idle_o     <= 1'b1;
                    idle_armed <= 1'b0;
                    idle_cnt   <= '0;
                end else begin
                    idle_cnt <= idle_cnt + TW'(1);
                end
            end
        end
    end

    assign unused_rec_bits = ^rec_char_i;

endmodule

// File: tb/tb_rx_char_controller.sv
// Directed bench for rx_char_controller: sequencing, FIFO ordering and
// boundaries, overrun handling, idle timeout and asynchronous reset.
module tb_rx_char_controller;

    localparam int DATA_BITS = 7;
    localparam int TIMEOUT   = 306;

    logic                 clk;
    logic                 rst_n;
    logic                 enable;
    logic                 clear;
    logic                 rec_rst;
    logic [7:0]           rec_char;
    logic                 rec_valid;
    logic [DATA_BITS-1:0] data;
    logic                 data_valid;
    logic                 data_ready;
    logic [2:0]           count;
    logic                 overrun;
    logic                 idle;
    logic [1:0]           state;

    int checks = 0;
    int errors = 0;

    rx_char_controller dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .enable_i     (enable),
        .clear_i      (clear),
        .rec_rst_o    (rec_rst),
        .rec_char_i   (rec_char),
        .rec_valid_i  (rec_valid),
        .data_o       (data),
        .data_valid_o (data_valid),
        .data_ready_i (data_ready),
        .count_o      (count),
        .overrun_o    (overrun),
        .idle_o       (idle),
        .state_o      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 ns after each rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_char(input logic [7:0] c);
        rec_char  = c;
        rec_valid = 1'b1;
        tick();
        rec_valid = 1'b0;
    endtask

    task automatic go_run();
        enable = 1'b1;
        repeat (3) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b1; enable = 1'b0; clear = 1'b0; rec_char = 8'h00;
        rec_valid = 1'b0; data_ready = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        checks++;
        if (rec_rst !== 1'b1 || data_valid !== 1'b0 || count !== 3'd0 ||
            overrun !== 1'b0 || idle !== 1'b0 || state !== 2'd0) begin
            errors++;
            $display("FAIL reset_values: rec_rst=%b valid=%b count=%0d ovr=%b idle=%b state=%0d, want 1 0 0 0 0 0",
                     rec_rst, data_valid, count, overrun, idle, state);
        end
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        checks++;
        if (state !== 2'd0 || rec_rst !== 1'b1) begin
            errors++;
            $display("FAIL stay_disabled: state=%0d rec_rst=%b, want 0 1", state, rec_rst);
        end
        enable = 1'b1;
        rec_valid = 1'b1;
        rec_char = 8'h7e;
        // DISABLED cycle then two FLUSH cycles hold the receiver in reset
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rec_rst !== (i < 3) || data_valid !== 1'b0) begin
                errors++;
                $display("FAIL enable_seq[%0d]: rec_rst=%b valid=%b, want %b 0", i, rec_rst, data_valid, i < 3);
            end
            if (i < 3) tick();
        end
        rec_valid = 1'b0;
        checks++;
        if (state !== 2'd2) begin
            errors++;
            $display("FAIL enable_state: state=%0d, want 2", state);
        end
    endtask

    task automatic test_flush_abort();
        enable = 1'b0;
        tick();
        enable = 1'b1;
        tick();
        enable = 1'b0;
        tick();
        checks++;
        if (state !== 2'd0 || rec_rst !== 1'b1) begin
            errors++;
            $display("FAIL flush_abort: state=%0d rec_rst=%b, want 0 1", state, rec_rst);
        end
        go_run();
    endtask

    task automatic test_order();
        logic [6:0] exp_c [3];
        exp_c[0] = 7'h41; exp_c[1] = 7'h42; exp_c[2] = 7'h43;
        push_char(8'h41);
        checks++;
        if (data_valid !== 1'b1 || data !== 7'h41) begin
            errors++;
            $display("FAIL fwft: valid=%b data=%h, want 1 41", data_valid, data);
        end
        push_char(8'h42);
        push_char(8'h43);
        checks++;
        if (count !== 3'd3 || data !== 7'h41) begin
            errors++;
            $display("FAIL order_fill: count=%0d data=%h, want 3 41", count, data);
        end
        data_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (data_valid !== 1'b1 || data !== exp_c[i]) begin
                errors++;
                $display("FAIL order_pop[%0d]: valid=%b data=%h, want 1 %h", i, data_valid, data, exp_c[i]);
            end
            tick();
        end
        checks++;
        if (data_valid !== 1'b0 || count !== 3'd0) begin
            errors++;
            $display("FAIL order_empty: valid=%b count=%0d, want 0 0", data_valid, count);
        end
        data_ready = 1'b0;
    endtask

    task automatic test_empty_push_pop();
        data_ready = 1'b1;
        push_char(8'hA0);
        checks++;
        if (count !== 3'd1 || data !== 7'h20) begin
            errors++;
            $display("FAIL empty_push_pop: count=%0d data=%h, want 1 20", count, data);
        end
        tick();
        data_ready = 1'b0;
        checks++;
        if (count !== 3'd0) begin
            errors++;
            $display("FAIL empty_drain: count=%0d, want 0", count);
        end
    endtask

    task automatic test_overrun();
        for (int i = 0; i < 5; i++) begin
            push_char(8'h10 + 8'(i));
            checks++;
            if (count !== ((i < 4) ? 3'(i + 1) : 3'd4) || overrun !== (i == 4)) begin
                errors++;
                $display("FAIL overrun_fill[%0d]: count=%0d ovr=%b", i, count, overrun);
            end
        end
        checks++;
        if (data !== 7'h10) begin
            errors++;
            $display("FAIL overrun_head: data=%h, want 10", data);
        end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        checks++;
        if (overrun !== 1'b0 || count !== 3'd4) begin
            errors++;
            $display("FAIL overrun_clear: ovr=%b count=%0d, want 0 4", overrun, count);
        end
        clear = 1'b1;
        push_char(8'h66);
        clear = 1'b0;
        checks++;
        if (overrun !== 1'b1) begin
            errors++;
            $display("FAIL clear_vs_drop: ovr=%b, want 1", overrun);
        end
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic test_full_push_pop();
        logic [6:0] exp_c [4];
        exp_c[0] = 7'h11; exp_c[1] = 7'h12; exp_c[2] = 7'h13; exp_c[3] = 7'h55;
        data_ready = 1'b1;
        push_char(8'h55);
        data_ready = 1'b0;
        checks++;
        if (count !== 3'd4 || overrun !== 1'b0 || data !== 7'h11) begin
            errors++;
            $display("FAIL full_push_pop: count=%0d ovr=%b data=%h, want 4 0 11", count, overrun, data);
        end
        data_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (data !== exp_c[i]) begin
                errors++;
                $display("FAIL full_drain[%0d]: data=%h, want %h", i, data, exp_c[i]);
            end
            tick();
        end
        data_ready = 1'b0;
    endtask

    task automatic test_disable();
        push_char(8'h31);
        push_char(8'h32);
        enable = 1'b0;
        tick();
        checks++;
        if (rec_rst !== 1'b1 || state !== 2'd0) begin
            errors++;
            $display("FAIL disable_rst: rec_rst=%b state=%0d, want 1 0", rec_rst, state);
        end
        push_char(8'h77);
        checks++;
        if (count !== 3'd2) begin
            errors++;
            $display("FAIL disable_ignore: count=%0d, want 2", count);
        end
        data_ready = 1'b1;
        checks++;
        if (data !== 7'h31) begin
            errors++;
            $display("FAIL disable_drain0: data=%h, want 31", data);
        end
        tick();
        checks++;
        if (data !== 7'h32 || data_valid !== 1'b1) begin
            errors++;
            $display("FAIL disable_drain1: data=%h valid=%b, want 32 1", data, data_valid);
        end
        tick();
        checks++;
        if (data_valid !== 1'b0) begin
            errors++;
            $display("FAIL disable_empty: valid=%b, want 0", data_valid);
        end
        go_run();
    endtask

    task automatic test_idle();
        int pulses;
        int first_at;
        enable = 1'b0;
        tick();
        go_run();
        data_ready = 1'b1;
        pulses = 0;
        for (int n = 0; n < 400; n++) begin
            tick();
            if (idle === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL idle_unarmed: pulses=%0d, want 0", pulses);
        end
        push_char(8'h01);
        pulses = 0; first_at = -1;
        for (int n = 1; n <= TIMEOUT + 20; n++) begin
            tick();
            if (idle === 1'b1) begin
                pulses++;
                if (first_at < 0) first_at = n;
            end
        end
        checks++;
        if (pulses != 1 || first_at != TIMEOUT) begin
            errors++;
            $display("FAIL idle_single: pulses=%0d at=%0d, want 1 at %0d", pulses, first_at, TIMEOUT);
        end
        push_char(8'h02);
        pulses = 0; first_at = -1;
        for (int n = 1; n <= 520; n++) begin
            if (n == 200) begin
                rec_char = 8'h03;
                rec_valid = 1'b1;
            end
            tick();
            rec_valid = 1'b0;
            if (idle === 1'b1) begin
                pulses++;
                if (first_at < 0) first_at = n;
            end
        end
        checks++;
        if (pulses != 1 || first_at != 200 + TIMEOUT) begin
            errors++;
            $display("FAIL idle_restart: pulses=%0d at=%0d, want 1 at %0d", pulses, first_at, 200 + TIMEOUT);
        end
        data_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) push_char(8'h20 + 8'(i));
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (rec_rst !== 1'b1 || data_valid !== 1'b0 || count !== 3'd0 ||
            overrun !== 1'b0 || idle !== 1'b0 || state !== 2'd0) begin
            errors++;
            $display("FAIL reset_mid: rec_rst=%b valid=%b count=%0d ovr=%b idle=%b state=%0d, want 1 0 0 0 0 0",
                     rec_rst, data_valid, count, overrun, idle, state);
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_flush_abort();
        test_order();
        test_empty_push_pop();
        test_overrun();
        test_full_push_pop();
        test_disable();
        test_idle();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rx_char_controller.md
RX_CHAR_CONTROLLER -- requirements
Module: rx_char_controller

Interface
REQ-001 Parameter DATA_BITS, default 7: character width delivered by the character recovery receiver.
REQ-002 Parameter OVERSAMPLING, default 17: clock cycles per bit period.
REQ-003 Parameter FIFO_DEPTH, default 4, power of two, minimum 2: number of buffered characters.
REQ-004 Parameter IDLE_CHARS, default 2: idle-line timeout measured in character times; TIMEOUT_CYCLES = OVERSAMPLING*(DATA_BITS+2)*IDLE_CHARS.
REQ-005 clk_i  input  1  single clock; all logic is clocked on the rising edge.
REQ-006 rst_n_i  input  1  asynchronous, active-low reset.
REQ-007 enable_i  input  1  receiver enable, level-sensitive.
REQ-008 clear_i  input  1  one-cycle pulse that clears overrun_o.
REQ-009 rec_rst_o  output  1  synchronous active-high reset driven to the character recovery receiver.
REQ-010 rec_char_i  input  8  received character from the receiver; only bits [DATA_BITS-1:0] are used.
REQ-011 rec_valid_i  input  1  one-cycle strobe marking rec_char_i valid.
REQ-012 data_o  output  DATA_BITS  head-of-FIFO character.
REQ-013 data_valid_o  output  1  FIFO not empty.
REQ-014 data_ready_i  input  1  consumer accepts data_o.
REQ-015 count_o  output  clog2(FIFO_DEPTH+1)  current FIFO occupancy.
REQ-016 overrun_o  output  1  sticky flag: a character was dropped.
REQ-017 idle_o  output  1  one-cycle pulse on idle-line timeout.

Function
REQ-018 The FSM SHALL have three states: DISABLED, FLUSH and RUN.
REQ-019 DISABLED: rec_rst_o=1, rec_valid_i ignored; when enable_i=1, go to FLUSH.
REQ-020 FLUSH: rec_rst_o=1 for exactly 2 cycles, then go to RUN; enable_i=0 during FLUSH returns to DISABLED on the next cycle.
REQ-021 RUN: rec_rst_o=0; when enable_i=0, go to DISABLED on the next cycle, with rec_rst_o=1 from that cycle.
REQ-022 Push: in RUN, rec_valid_i=1 writes rec_char_i[DATA_BITS-1:0] to the FIFO tail.
REQ-023 Pop: data_valid_o=1 and data_ready_i=1 in the same cycle advances the head; pops are legal in every state.
REQ-024 The FIFO SHALL be first-word fall-through: a push into an empty FIFO makes data_valid_o=1 and data_o equal to the character on the following cycle.
REQ-025 FIFO contents SHALL be retained across DISABLED; they are discarded only by rst_n_i.
REQ-026 Full with push and no pop: drop the character, set overrun_o=1 on the next cycle, leave contents and count unchanged.
REQ-027 Full with push and pop in the same cycle: both take effect, count stays FIFO_DEPTH, overrun_o unchanged.
REQ-028 Empty with push and data_ready_i=1 in the same cycle: no pop occurs (data_valid_o was 0), count becomes 1.
REQ-029 count_o SHALL equal the number of stored entries, range 0..FIFO_DEPTH; read and write pointers wrap modulo FIFO_DEPTH.
REQ-030 overrun_o SHALL hold until clear_i=1; if clear_i and a new overrun occur in the same cycle, the overrun wins and overrun_o stays 1.
REQ-031 Idle timer, arming: in RUN, each rec_valid_i restarts the idle counter at 0 and arms it, including a rec_valid_i whose character is dropped.
REQ-032 Idle timer, firing: while armed, the counter increments each cycle; the cycle after it reaches TIMEOUT_CYCLES-1, idle_o=1 for one cycle and the timer disarms.
REQ-033 Idle timer, disarm: leaving RUN disarms the timer and clears the counter; idle_o never fires unless at least one character was received since the last timeout or enable.

Reset
REQ-034 While rst_n_i=0, asynchronously: state=DISABLED, rec_rst_o=1, data_valid_o=0, count_o=0, overrun_o=0, idle_o=0, FIFO pointers=0, idle timer disarmed with counter 0.
REQ-035 After rst_n_i deasserts, the block SHALL remain in DISABLED until enable_i=1 is sampled.

Verification
REQ-036 Reset, enable_i=1: rec_rst_o=1 for the DISABLED cycle plus 2 FLUSH cycles, then 0; data_valid_o=0 throughout.
REQ-037 In RUN, push 0x41, 0x42, 0x43 with data_ready_i=0: count_o=3, data_o=0x41; then hold data_ready_i=1: pops 0x41, 0x42, 0x43 in order, then data_valid_o=0.
REQ-038 Push 5 characters into a depth-4 FIFO without pops: count_o=4, overrun_o=1, head=first character; clear_i pulse: overrun_o=0.
REQ-039 FIFO full, push and pop in the same cycle: count_o stays 4, overrun_o stays 0, and the new character becomes the tail.
REQ-040 Defaults (TIMEOUT_CYCLES=306): one character, then silence -> idle_o pulses once 306 cycles after the strobe; a second character at cycle 200 restarts the count.
REQ-041 enable_i=0 with 2 buffered characters: rec_rst_o=1 next cycle, subsequent rec_valid_i ignored, both characters still drain; rst_n_i=0 mid-operation -> all outputs take their reset values immediately.
